// File: rtl/lms_dac_iq_deinterleaver_pkg.sv
// Purpose: shared constants, FSM encoding and helpers for the LMS DAC I/Q deinterleaver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lms_dac_iq_deinterleaver_pkg;

  localparam int   DW         = 12;    // sample width, matches TXD/RXD
  localparam logic I_LEVEL    = 1'b0;  // IQSEL level that marks the I word
  localparam int   FIFO_AW    = 2;     // pair FIFO depth = 2**FIFO_AW
  localparam int   PAIR_CNT_W = 32;
  localparam int   ERR_CNT_W  = 16;

  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } fsm_state_e;

  // Saturating increment for the error counter: sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lms_iq_pair_fifo.sv
// Purpose: first-word-fall-through FIFO of I/Q pairs; head holds last popped word when empty.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push when full is refused unless a pop happens in the same cycle.
module lms_iq_pair_fifo #(
  parameter int W  = 24,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         push_acc,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  last_q;
  logic          full;
  logic          pop_ok;

  // Occupancy never exceeds DEPTH, so the MSB alone flags full.
  assign full     = cnt_q[AW];
  assign empty    = (cnt_q == '0);
  assign pop_ok   = pop && !empty;
  assign push_acc = push && (!full || pop_ok);
  assign head_dat = empty ? last_q : mem_q[rd_ptr_q];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_dat;
  end

  // Pointers, occupancy and the hold copy of the last popped head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({push_acc, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/lms_dac_iq_deinterleaver.sv
// Purpose: rebuilds I/Q pairs from the interleaved TXD/IQSEL bus, checks framing, keeps stats.
// Latency: I on pins cycle n, Q cycle n+1 -> out_valid at n+3 (input reg, pair form, FIFO write).
// Backpressure: out_valid/out_ready; pairs arriving while the FIFO is full are dropped and flagged.
module lms_dac_iq_deinterleaver
  import lms_dac_iq_deinterleaver_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_stats,
  input  logic                  iqsel,
  input  logic [DW-1:0]         txd,
  output logic [DW-1:0]         out_i,
  output logic [DW-1:0]         out_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic [PAIR_CNT_W-1:0] pair_count,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  overflow
);

  logic                  iqsel_q;
  logic [DW-1:0]         txd_q;
  fsm_state_e            state_q, state_d;
  logic [DW-1:0]         i_hold_q, i_hold_d;
  logic [1:0]            good_cnt_q, good_cnt_d;
  logic                  locked_q, locked_d;
  logic                  frame_err;
  logic                  push_req;
  logic                  push_acc;
  logic                  fifo_empty;
  logic [2*DW-1:0]       head_dat;
  logic [PAIR_CNT_W-1:0] pair_count_q;
  logic [ERR_CNT_W-1:0]  err_count_q;
  logic                  overflow_q;

  // Single capture stage for the bus; idle value is the non-I level so it never starts a pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iqsel_q <= ~I_LEVEL;
      txd_q   <= '0;
    end else begin
      iqsel_q <= iqsel;
      txd_q   <= txd;
    end
  end

  // FSM, held I word and lock tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_I;
      i_hold_q   <= '0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_hold_q   <= i_hold_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // Framing decode: pair forming, resync on newest I, lock after two clean pairs.
  always_comb begin
    state_d    = state_q;
    i_hold_d   = i_hold_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    frame_err  = 1'b0;
    push_req   = 1'b0;
    if (!enable) begin
      state_d    = WAIT_I;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_I: begin
          if (iqsel_q == I_LEVEL) begin
            i_hold_d = txd_q;
            state_d  = WAIT_Q;
          end else if (locked_q) begin
            // A Q word while waiting for I only counts as an error once framing is trusted.
            frame_err  = 1'b1;
            good_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end
        WAIT_Q: begin
          if (iqsel_q != I_LEVEL) begin
            state_d  = WAIT_I;
            // The first clean pair only primes the lock; the second one is already emitted.
            push_req = locked_q || (good_cnt_q == 2'd1);
            if (good_cnt_q != 2'd2) good_cnt_d = good_cnt_q + 2'd1;
            if (good_cnt_q != 2'd0) locked_d = 1'b1;
          end else begin
            // Two I words in a row: drop the older one and pair against the newest.
            frame_err  = 1'b1;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            i_hold_d   = txd_q;
          end
        end
        default: state_d = WAIT_I;
      endcase
    end
  end

  lms_iq_pair_fifo #(
    .W  (2*DW),
    .AW (FIFO_AW)
  ) u_pair_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_dat ({i_hold_q, txd_q}),
    .push_acc (push_acc),
    .pop      (out_ready),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  // Statistics; a clear in the same cycle as an event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_count_q <= '0;
      err_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else if (clear_stats) begin
      pair_count_q <= '0;
      err_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push_acc)              pair_count_q <= pair_count_q + 1'b1;
      if (frame_err)             err_count_q  <= sat_inc(err_count_q);
      if (push_req && !push_acc) overflow_q   <= 1'b1;
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_i      = head_dat[2*DW-1:DW];
  assign out_q      = head_dat[DW-1:0];
  assign locked     = locked_q;
  assign pair_count = pair_count_q;
  assign err_count  = err_count_q;
  assign overflow   = overflow_q;

endmodule
